// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one async SRAM between the Atari cartridge bus (PHI2-timed, absolute priority)
// and a microcontroller using a 4-phase req/ack handshake; every access is four clk phases t0..t3.
module ram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fi2,
  input  logic              cart_req,
  input  logic              cart_we,
  input  logic [ADDR_W-1:0] cart_addr,
  input  logic [DATA_W-1:0] cart_wdata,
  output logic [DATA_W-1:0] cart_rdata,
  output logic              cart_done,
  input  logic              uc_req,
  input  logic              uc_we,
  input  logic [ADDR_W-1:0] uc_addr,
  input  logic [DATA_W-1:0] uc_wdata,
  output logic [DATA_W-1:0] uc_rdata,
  output logic              uc_ack,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  output logic              ram_dout_en,
  input  logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              cart_overrun
);
  typedef enum logic [1:0] {IDLE, CART, UC, UC_HOLD} state_t;
  state_t state, state_n;
  logic [1:0] phase;
  logic fi2_m, fi2_s, fi2_d, fi2_rise, fi2_fall, fi2_low;
  logic cart_hit, active, last, start_cart, start_uc, set_pending, overrun;
  logic cart_pending, a_we, p_we;
  logic [ADDR_W-1:0] a_addr, p_addr;
  logic [DATA_W-1:0] a_wdata, p_wdata;
  assign fi2_rise = fi2_s & ~fi2_d;
  assign fi2_fall = ~fi2_s & fi2_d;
  assign fi2_low = fi2_fall | ~fi2_s;
  assign cart_hit = fi2_rise & cart_req;
  assign active = state == CART || state == UC;
  assign last = phase == 2'd3;
  // a cart request seen while the uC owns the RAM is parked and taken right as the uC access ends
  assign start_cart = (state == IDLE || (state == UC && last)) && (cart_pending || cart_hit);
  assign start_uc = state == IDLE && !cart_pending && !cart_hit && !fi2_rise && fi2_low && uc_req && !uc_ack;
  assign set_pending = cart_hit && !cart_pending && (state == UC_HOLD || (state == UC && !last));
  assign overrun = cart_hit && (cart_pending || state == CART);
  always_comb begin
    state_n = state;
    if (start_cart) state_n = CART;
    else if (start_uc) state_n = UC;
    else if (state == CART && last) state_n = IDLE;
    else if (state == UC && last) state_n = UC_HOLD;
    else if (state == UC_HOLD && !uc_req) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fi2_m <= 1'b0;
      fi2_s <= 1'b0;
      fi2_d <= 1'b0;
      state <= IDLE;
      phase <= 2'd0;
      a_we <= 1'b0;
      a_addr <= '0;
      a_wdata <= '0;
      p_we <= 1'b0;
      p_addr <= '0;
      p_wdata <= '0;
      cart_pending <= 1'b0;
      cart_overrun <= 1'b0;
      uc_ack <= 1'b0;
      cart_rdata <= '0;
      uc_rdata <= '0;
    end else begin
      fi2_m <= fi2;
      fi2_s <= fi2_m;
      fi2_d <= fi2_s;
      state <= state_n;
      phase <= active ? phase + 2'd1 : 2'd0;
      if (start_cart) begin
        a_we <= cart_pending ? p_we : cart_we;
        a_addr <= cart_pending ? p_addr : cart_addr;
        a_wdata <= cart_pending ? p_wdata : cart_wdata;
      end else if (start_uc) begin
        a_we <= uc_we;
        a_addr <= uc_addr;
        a_wdata <= uc_wdata;
      end
      if (set_pending) begin
        p_we <= cart_we;
        p_addr <= cart_addr;
        p_wdata <= cart_wdata;
      end
      cart_pending <= set_pending | (cart_pending & ~start_cart);
      cart_overrun <= cart_overrun | overrun;
      uc_ack <= (state == UC && last) | (uc_ack & uc_req);
      if (active && !a_we && phase == 2'd2 && state == CART) cart_rdata <= ram_din;
      if (active && !a_we && phase == 2'd2 && state == UC) uc_rdata <= ram_din;
    end
  assign ram_addr = a_addr;
  assign ram_oe_n = ~(active & ~a_we);
  assign ram_we_n = ~(active & a_we & (phase == 2'd1 || phase == 2'd2));
  assign ram_dout_en = active & a_we;
  assign ram_dout = ram_dout_en ? a_wdata : '0;
  assign cart_done = state == CART && last;
  assign busy = state != IDLE || cart_pending;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of cart/uC arbitration, SRAM strobes, overrun and async reset.
module tb_ram_arbiter;
  logic clk = 1'b0, reset = 1'b1, fi2 = 1'b0;
  logic cart_req = 1'b0, cart_we = 1'b0, uc_req = 1'b0, uc_we = 1'b0;
  logic [14:0] cart_addr = '0, uc_addr = '0, ram_addr;
  logic [7:0] cart_wdata = '0, uc_wdata = '0, ram_din = '0, cart_rdata, uc_rdata, ram_dout;
  logic cart_done, uc_ack, ram_oe_n, ram_we_n, ram_dout_en, busy, cart_overrun;
  int checks = 0, failures = 0;
  ram_arbiter dut (
    .clk(clk), .reset(reset), .fi2(fi2),
    .cart_req(cart_req), .cart_we(cart_we), .cart_addr(cart_addr), .cart_wdata(cart_wdata),
    .cart_rdata(cart_rdata), .cart_done(cart_done),
    .uc_req(uc_req), .uc_we(uc_we), .uc_addr(uc_addr), .uc_wdata(uc_wdata),
    .uc_rdata(uc_rdata), .uc_ack(uc_ack),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .ram_dout_en(ram_dout_en), .ram_din(ram_din), .busy(busy), .cart_overrun(cart_overrun)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_oe"}, ram_oe_n, 1);
    chk({tag, "_we"}, ram_we_n, 1);
    chk({tag, "_den"}, ram_dout_en, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_dout"}, ram_dout, 0);
    chk({tag, "_crd"}, cart_rdata, 0);
    chk({tag, "_urd"}, uc_rdata, 0);
    chk({tag, "_done"}, cart_done, 0);
    chk({tag, "_ack"}, uc_ack, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovr"}, cart_overrun, 0);
  endtask
  initial begin
    tick(2);
    chk_reset_vals("rst");
    reset = 1'b0;
    tick(2);
    chk("idle_busy", busy, 0);
    // cart read 0x1234 -> 0xA5
    cart_req = 1'b1; cart_we = 1'b0; cart_addr = 15'h1234; ram_din = 8'hA5; fi2 = 1'b1;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      chk("cr_oe", ram_oe_n, 0);
      chk("cr_we", ram_we_n, 1);
      chk("cr_addr", ram_addr, 15'h1234);
      chk("cr_done", cart_done, i == 3);
      chk("cr_ack", uc_ack, 0);
      if (i == 3) chk("cr_rdata", cart_rdata, 8'hA5);
      tick();
    end
    chk("cr_end_oe", ram_oe_n, 1);
    chk("cr_end_done", cart_done, 0);
    chk("cr_end_busy", busy, 0);
    chk("cr_hold_rdata", cart_rdata, 8'hA5);
    cart_req = 1'b0; fi2 = 1'b0; ram_din = 8'h00;
    tick(4);
    // uC write 0x7FFF <- 0x3C, then uc_req held high after ack
    uc_req = 1'b1; uc_we = 1'b1; uc_addr = 15'h7FFF; uc_wdata = 8'h3C;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("uw_den", ram_dout_en, 1);
      chk("uw_dout", ram_dout, 8'h3C);
      chk("uw_addr", ram_addr, 15'h7FFF);
      chk("uw_we", ram_we_n, (i == 1 || i == 2) ? 0 : 1);
      chk("uw_oe", ram_oe_n, 1);
      chk("uw_ack", uc_ack, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("uh_ack", uc_ack, 1);
      chk("uh_busy", busy, 1);
      chk("uh_den", ram_dout_en, 0);
      chk("uh_addr", ram_addr, 15'h7FFF);
      tick();
    end
    uc_req = 1'b0;
    tick();
    chk("uh_ack_clr", uc_ack, 0);
    chk("uh_busy_clr", busy, 0);
    // uC read 0x0055 -> 0x5A after re-request
    uc_req = 1'b1; uc_we = 1'b0; uc_addr = 15'h0055; ram_din = 8'h5A;
    tick();
    chk("ur_oe", ram_oe_n, 0);
    chk("ur_addr", ram_addr, 15'h0055);
    tick(3);
    chk("ur_rdata", uc_rdata, 8'h5A);
    chk("ur_cart_rdata", cart_rdata, 8'hA5);
    tick();
    chk("ur_ack", uc_ack, 1);
    uc_req = 1'b0; ram_din = 8'h00;
    tick();
    chk("ur_ack_clr", uc_ack, 0);
    // cart rise during UC t1
    uc_req = 1'b1; uc_we = 1'b1; uc_addr = 15'h0100; uc_wdata = 8'h11;
    cart_req = 1'b1; cart_we = 1'b0; cart_addr = 15'h0222; ram_din = 8'h77; fi2 = 1'b1;
    tick();
    chk("pr_t0_den", ram_dout_en, 1);
    chk("pr_t0_we", ram_we_n, 1);
    tick();
    chk("pr_t1_we", ram_we_n, 0);
    tick();
    chk("pr_t2_we", ram_we_n, 0);
    chk("pr_t2_busy", busy, 1);
    tick();
    chk("pr_t3_we", ram_we_n, 1);
    chk("pr_t3_addr", ram_addr, 15'h0100);
    tick();
    chk("pr_c0_oe", ram_oe_n, 0);
    chk("pr_c0_addr", ram_addr, 15'h0222);
    chk("pr_c0_den", ram_dout_en, 0);
    chk("pr_c0_ack", uc_ack, 1);
    tick(3);
    chk("pr_c3_done", cart_done, 1);
    chk("pr_c3_rdata", cart_rdata, 8'h77);
    tick();
    chk("pr_idle_busy", busy, 0);
    chk("pr_idle_ack", uc_ack, 1);
    chk("pr_idle_oe", ram_oe_n, 1);
    chk("pr_ovr", cart_overrun, 0);
    tick(2);
    chk("pr_noreissue_oe", ram_oe_n, 1);
    chk("pr_noreissue_den", ram_dout_en, 0);
    uc_req = 1'b0; cart_req = 1'b0; fi2 = 1'b0;
    tick();
    chk("pr_ack_clr", uc_ack, 0);
    tick(3);
    // two cart rises while uC sits in UC_HOLD
    uc_req = 1'b1; uc_we = 1'b0; uc_addr = 15'h0010;
    tick(5);
    chk("ov_hold_ack", uc_ack, 1);
    cart_req = 1'b1; cart_we = 1'b1; cart_addr = 15'h0333; cart_wdata = 8'h99; fi2 = 1'b1;
    tick(3);
    chk("ov_pend_busy", busy, 1);
    chk("ov_pend_den", ram_dout_en, 0);
    chk("ov_first", cart_overrun, 0);
    fi2 = 1'b0;
    tick(3);
    fi2 = 1'b1;
    tick(3);
    chk("ov_set", cart_overrun, 1);
    chk("ov_still_hold", ram_dout_en, 0);
    cart_req = 1'b0; uc_req = 1'b0;
    tick();
    chk("ov_idle_ack", uc_ack, 0);
    chk("ov_idle_busy", busy, 1);
    tick();
    chk("ov_c0_den", ram_dout_en, 1);
    chk("ov_c0_addr", ram_addr, 15'h0333);
    chk("ov_c0_dout", ram_dout, 8'h99);
    chk("ov_c0_we", ram_we_n, 1);
    tick();
    chk("ov_c1_we", ram_we_n, 0);
    chk("ov_c1_oe", ram_oe_n, 1);
    tick(2);
    chk("ov_c3_done", cart_done, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("ov_single_den", ram_dout_en, 0);
      chk("ov_single_done", cart_done, 0);
      tick();
    end
    chk("ov_sticky", cart_overrun, 1);
    // reset during cart write t1
    fi2 = 1'b0;
    tick(3);
    cart_req = 1'b1; cart_we = 1'b1; cart_addr = 15'h0444; cart_wdata = 8'hEE; fi2 = 1'b1;
    tick(4);
    chk("rw_t1_we", ram_we_n, 0);
    chk("rw_t1_den", ram_dout_en, 1);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("rw");
    cart_req = 1'b0; fi2 = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rw_no_done", cart_done, 0);
      chk("rw_no_busy", busy, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
